lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: takes one load or store request at a time from the
// pipeline, drives a registered request onto the data bus, waits for the
// grant and (for loads) the read return, then aligns and extends the load
// data and signals completion to writeback with a one-cycle pulse.
// A watchdog bounds the time spent waiting on the bus.
// Optional feature: define LSU_MISALIGN_TRAP_EN to report misaligned half and
// word accesses as errors instead of silently ignoring the low address bits.
module lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // Last counter value before the watchdog fires; the counter starts at 0 in
  // the first ADDR cycle, so this gives exactly MAX_WAIT bus-wait cycles.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt;
  logic        timeout;
  logic        req_err;
  logic        misalign;
  logic        err_d;

  logic [1:0]  lane;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign timeout    = (wait_cnt == WAIT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == 2'b11) || misalign;

  // Request decode: effective byte lane, byte enables and replicated store data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    lane    = 2'b00;
    be_d    = 4'b0000;
    wdata_d = req_wdata;
    case (req_size)
      2'b00: begin
        lane    = req_addr[1:0];
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane    = {req_addr[1], 1'b0};
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
      default: begin
        be_d    = 4'b0000;
      end
    endcase
  end

  // Load alignment: move the addressed lane to bit 0, then extend.
  always_comb begin
    shifted   = dmem_rdata >> {lane_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_q ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Next-state logic; err_d marks entries into RESP that complete with an error.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (dmem_gnt) begin
          state_d = dmem_we ? RESP : DATA;
        end
      end
      DATA: begin
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (dmem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus request registers, latched request fields, load result and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      lsu_rdata  <= 32'h0;
      lsu_err    <= 1'b0;
      wait_cnt   <= 8'h0;
    end else begin
      lsu_err <= err_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wait_cnt <= 8'h0;
            if (!req_err) begin
              dmem_req   <= 1'b1;
              dmem_we    <= req_we;
              dmem_be    <= be_d;
              dmem_addr  <= {req_addr[31:2], 2'b00};
              dmem_wdata <= wdata_d;
              size_q     <= req_size;
              unsigned_q <= req_unsigned;
              lane_q     <= lane;
            end
          end
        end
        ADDR: begin
          wait_cnt <= wait_cnt + 8'h1;
          if (timeout) begin
            dmem_req  <= 1'b0;
            lsu_rdata <= 32'h0;
          end else if (dmem_gnt) begin
            dmem_req <= 1'b0;
          end
        end
        DATA: begin
          wait_cnt <= wait_cnt + 8'h1;
          if (timeout) begin
            lsu_rdata <= 32'h0;
          end else if (dmem_rvalid) begin
            lsu_rdata <= load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit. The stimulus process drives the
// pipeline request and plays the bus, checking the bus-side fields as they
// appear; it pushes each expected completion into a queue, and a separate
// monitor pops and compares whenever resp_valid is seen.
module tb_lsu;

  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .lsu_rdata    (lsu_rdata),
    .lsu_err      (lsu_err),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] model_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every resp_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_resp_cycle"}, cyc, e.cyc);
        check({e.name, "_err"}, {31'b0, lsu_err}, {31'b0, e.err});
        check({e.name, "_rdata"}, lsu_rdata, e.rdata);
      end
    end
  end

  // One request from accept to completion. gnt_wait<0 withholds the grant.
  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_wait,
                         input logic [31:0] bus_rdata, input logic exp_bus,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_lat);
    int   t0;
    int   n;
    exp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    t0 = cyc;
    check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    if (exp_bus && !we) model_rdata = exp_rdata;
    e.cyc   = t0 + exp_lat;
    e.err   = exp_err;
    e.rdata = model_rdata;
    e.name  = name;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    if (!exp_bus) begin
      check({name, "_no_req"}, {31'b0, dmem_req}, 32'd0);
    end else begin
      n = (gnt_wait < 0) ? MAX_WAIT : gnt_wait + 1;
      for (int k = 0; k < n; k++) begin
        check({name, "_req"}, {31'b0, dmem_req}, 32'd1);
        check({name, "_we"}, {31'b0, dmem_we}, {31'b0, we});
        check({name, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        check({name, "_addr"}, dmem_addr, exp_addr);
        check({name, "_wdata"}, dmem_wdata, exp_wdata);
        if (gnt_wait >= 0 && k == n - 1) begin
          dmem_gnt    = 1'b1;
          dmem_rvalid = 1'b0;
        end else begin
          // Stray read returns while waiting for the grant must be ignored.
          dmem_rvalid = 1'b1;
          dmem_rdata  = 32'hDEAD_DEAD;
        end
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
      end
      if (gnt_wait < 0) begin
        check({name, "_req_drop"}, {31'b0, dmem_req}, 32'd0);
      end else if (!we) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = bus_rdata;
        tick();
        dmem_rvalid = 1'b0;
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 32'h0;
    #2;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_err", {31'b0, lsu_err}, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_dmem_fields", {dmem_we, dmem_be, 27'b0} | dmem_addr | dmem_wdata, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    //       name      we    size   uns   addr          wdata         gnt bus_rdata     bus   be       addr          wdata         err   rdata         lat
    run_txn("lb_103",  1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        0, 32'h80FF_FF00, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        1'b0, 32'hFFFF_FF80, 3);
    run_txn("lbu_103", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        0, 32'h80FF_FF00, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        1'b0, 32'h0000_0080, 3);
    run_txn("sh_202",  1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0,        1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 1'b0, 32'h0,        2);
    run_txn("lh_wait", 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        5, 32'h80FF_1234, 1'b1, 4'b1100, 32'h0000_0200, 32'h0,        1'b0, 32'hFFFF_80FF, 8);
    run_txn("lhu_200", 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        0, 32'h80FF_9ABC, 1'b1, 4'b0011, 32'h0000_0200, 32'h0,        1'b0, 32'h0000_9ABC, 3);
    run_txn("sb_301",  1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'hFFFF_FF5A, 2, 32'h0,        1'b1, 4'b0010, 32'h0000_0300, 32'h5A5A_5A5A, 1'b0, 32'h0,        4);
    run_txn("sw_404",  1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 0, 32'h0,        1'b1, 4'b1111, 32'h0000_0404, 32'hDEAD_BEEF, 1'b0, 32'h0,        2);
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn("lw_101",  1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h1122_3344, 1'b0, 4'b0000, 32'h0,         32'h0,        1'b1, 32'h0,        1);
`else
    run_txn("lw_101",  1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h1122_3344, 1'b1, 4'b1111, 32'h0000_0100, 32'h0,        1'b0, 32'h1122_3344, 3);
`endif
    run_txn("illegal", 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        0, 32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,        1'b1, 32'h0,        1);
    run_txn("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0,       -1, 32'h0,        1'b1, 4'b1111, 32'h0000_0500, 32'h0,        1'b1, 32'h0,        9);
    run_txn("lw_600",  1'b0, 2'b10, 1'b1, 32'h0000_0600, 32'h0,        0, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0000_0600, 32'h0,        1'b0, 32'hCAFE_F00D, 3);

    // Reset while a load sits in DATA; the late read return must be ignored.
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_0700;
    tick();
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("midrst_rdata", lsu_rdata, 32'd0);
    check("midrst_dmem_addr", dmem_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("midrst_late_rdata", lsu_rdata, 32'd0);
    check("midrst_late_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_late_resp", {31'b0, resp_valid}, 32'd0);
    model_rdata = 32'h0;
    repeat (3) tick();

    run_txn("lbu_001", 1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,        0, 32'h0000_AB00, 1'b1, 4'b0010, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_00AB, 3);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
